// File: rtl/renkon_dispatch.sv
// renkon_dispatch -- loads per-core net (weight) memories for one layer, one
// group of RENKON_CORE output channels at a time, then hands each group to
// the accelerator through a req/ack handshake.
//
// Parameter defaults match the renkon.svh values:
//   RENKON_CORE=8, RENKON_CORELOG=3, RENKON_NETSIZE=11,
//   DWIDTH=16, LWIDTH=10, IMGSIZE=12.
//
// Ports
//   clk, xrst                 clock (rising edge), synchronous active-high reset
//   start                     layer start pulse, accepted only when idle
//   cfg_*                     layer geometry / base addresses, captured on start
//   w_valid, w_data, w_ready  weight stream
//   net_sel/we/addr/wdata     net memory write port (core select + address)
//   req, ack                  accelerator handshake, one req per group
//   in_offset .. fil_size     captured layer parameters for the accelerator
//   busy, done                activity flag, one-cycle completion pulse
//
// Optional: define RENKON_DISPATCH_PERF_EN to add perf_load_cycles and
// perf_wait_cycles (32-bit saturating LOAD / WAIT cycle counters).
module renkon_dispatch #(
    parameter int RENKON_CORE    = 8,
    parameter int RENKON_CORELOG = 3,
    parameter int RENKON_NETSIZE = 11,
    parameter int DWIDTH         = 16,
    parameter int LWIDTH         = 10,
    parameter int IMGSIZE        = 12
) (
    input  logic                        clk,
    input  logic                        xrst,
    input  logic                        start,
    input  logic [LWIDTH-1:0]           cfg_total_out,
    input  logic [LWIDTH-1:0]           cfg_total_in,
    input  logic [LWIDTH-1:0]           cfg_fil_size,
    input  logic [IMGSIZE-1:0]          cfg_in_offset,
    input  logic [IMGSIZE-1:0]          cfg_out_offset,
    input  logic [IMGSIZE-1:0]          cfg_out_stride,
    input  logic [RENKON_NETSIZE-1:0]   cfg_net_offset,
    input  logic                        w_valid,
    input  logic signed [DWIDTH-1:0]    w_data,
    output logic                        w_ready,
    output logic [RENKON_CORELOG-1:0]   net_sel,
    output logic                        net_we,
    output logic [RENKON_NETSIZE-1:0]   net_addr,
    output logic signed [DWIDTH-1:0]    net_wdata,
    output logic                        req,
    input  logic                        ack,
    output logic [IMGSIZE-1:0]          in_offset,
    output logic [IMGSIZE-1:0]          out_offset,
    output logic [RENKON_NETSIZE-1:0]   net_offset,
    output logic [LWIDTH-1:0]           total_out,
    output logic [LWIDTH-1:0]           total_in,
    output logic [LWIDTH-1:0]           fil_size,
    output logic                        busy,
    output logic                        done
`ifdef RENKON_DISPATCH_PERF_EN
    ,
    output logic [31:0]                 perf_load_cycles,
    output logic [31:0]                 perf_wait_cycles
`endif
);

    localparam int PW = 3 * LWIDTH;                  // full-width nw product
    localparam int CW = LWIDTH + RENKON_CORELOG + 1; // channel index width

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                      r_state, w_next;
    logic [RENKON_CORELOG-1:0]   r_core;
    logic [RENKON_NETSIZE-1:0]   r_word;
    logic [RENKON_NETSIZE-1:0]   r_nw;
    logic [LWIDTH-1:0]           r_group;
    logic [IMGSIZE-1:0]          r_stride;
    logic                        r_ended;
    logic [IMGSIZE-1:0]          r_in_offset, r_out_offset;
    logic [RENKON_NETSIZE-1:0]   r_net_offset;
    logic [LWIDTH-1:0]           r_total_out, r_total_in, r_fil_size;

    logic [PW-1:0]               w_nw_full;
    logic [CW-1:0]               w_grp_base, w_chan;
    logic                        w_active, w_adv, w_word_last, w_core_last, w_last_grp;

    assign w_nw_full   = PW'(cfg_total_in) * PW'(cfg_fil_size) * PW'(cfg_fil_size) + PW'(1);
    assign w_grp_base  = CW'(r_group) * CW'(RENKON_CORE);
    assign w_chan      = w_grp_base + CW'(r_core);
    // Cores beyond the remaining channels of the final group get zero words.
    assign w_active    = w_chan < CW'(r_total_out);
    assign w_adv       = (r_state == S_LOAD) && (w_active ? w_valid : 1'b1);
    assign w_word_last = r_word == (r_nw - RENKON_NETSIZE'(1));
    assign w_core_last = r_core == RENKON_CORELOG'(RENKON_CORE - 1);
    // Evaluated after the group counter has already been bumped by ack.
    assign w_last_grp  = w_grp_base >= CW'(r_total_out);

    assign in_offset  = r_in_offset;
    assign out_offset = r_out_offset;
    assign net_offset = r_net_offset;
    assign total_out  = r_total_out;
    assign total_in   = r_total_in;
    assign fil_size   = r_fil_size;

    always_ff @(posedge clk) begin
        if (xrst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req       = 1'b0;
        w_ready   = 1'b0;
        net_we    = 1'b0;
        net_sel   = '0;
        net_addr  = '0;
        net_wdata = '0;
        done      = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (cfg_total_out == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                net_sel   = r_core;
                net_addr  = r_net_offset + r_word;
                w_ready   = w_active;
                net_we    = w_active ? w_valid : 1'b1;
                net_wdata = w_active ? w_data : '0;
                if (w_adv && w_word_last && w_core_last) w_next = S_REQ;
            end
            S_REQ: begin
                req    = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // Group end is registered first, so the LOAD/DONE decision
                // sees the incremented group counter one cycle after ack.
                if (r_ended) w_next = w_last_grp ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            r_core       <= '0;
            r_word       <= '0;
            r_nw         <= '0;
            r_group      <= '0;
            r_stride     <= '0;
            r_ended      <= 1'b0;
            r_in_offset  <= '0;
            r_out_offset <= '0;
            r_net_offset <= '0;
            r_total_out  <= '0;
            r_total_in   <= '0;
            r_fil_size   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_core       <= '0;
                        r_word       <= '0;
                        r_group      <= '0;
                        r_ended      <= 1'b0;
                        r_nw         <= RENKON_NETSIZE'(w_nw_full);
                        r_stride     <= cfg_out_stride;
                        r_in_offset  <= cfg_in_offset;
                        r_out_offset <= cfg_out_offset;
                        r_net_offset <= cfg_net_offset;
                        r_total_out  <= cfg_total_out;
                        r_total_in   <= cfg_total_in;
                        r_fil_size   <= cfg_fil_size;
                    end
                end
                S_LOAD: begin
                    if (w_adv) begin
                        if (w_word_last) begin
                            r_word <= '0;
                            r_core <= w_core_last ? '0 : r_core + RENKON_CORELOG'(1);
                        end else begin
                            r_word <= r_word + RENKON_NETSIZE'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_ended) begin
                        r_ended <= 1'b0;
                    end else if (ack) begin
                        r_ended      <= 1'b1;
                        r_group      <= r_group + LWIDTH'(1);
                        r_out_offset <= r_out_offset + r_stride;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RENKON_DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (xrst) begin
            perf_load_cycles <= '0;
            perf_wait_cycles <= '0;
        end else if (r_state == S_IDLE && start) begin
            perf_load_cycles <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (r_state == S_LOAD && perf_load_cycles != '1)
                perf_load_cycles <= perf_load_cycles + 32'd1;
            if (r_state == S_WAIT && perf_wait_cycles != '1)
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_renkon_dispatch.sv
// Directed bench for renkon_dispatch (default parameters).
module tb_renkon_dispatch;

    logic        clk = 1'b0;
    logic        xrst, start, w_valid, ack;
    logic [9:0]  cfg_total_out, cfg_total_in, cfg_fil_size;
    logic [11:0] cfg_in_offset, cfg_out_offset, cfg_out_stride;
    logic [10:0] cfg_net_offset;
    logic signed [15:0] w_data;
    logic        w_ready, net_we, req, busy, done;
    logic [2:0]  net_sel;
    logic [10:0] net_addr, net_offset;
    logic signed [15:0] net_wdata;
    logic [11:0] in_offset, out_offset;
    logic [9:0]  total_out, total_in, fil_size;
`ifdef RENKON_DISPATCH_PERF_EN
    logic [31:0] perf_load_cycles, perf_wait_cycles;
`endif

    always #5 clk = ~clk;

    renkon_dispatch dut (
        .clk(clk), .xrst(xrst), .start(start),
        .cfg_total_out(cfg_total_out), .cfg_total_in(cfg_total_in), .cfg_fil_size(cfg_fil_size),
        .cfg_in_offset(cfg_in_offset), .cfg_out_offset(cfg_out_offset),
        .cfg_out_stride(cfg_out_stride), .cfg_net_offset(cfg_net_offset),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .net_sel(net_sel), .net_we(net_we), .net_addr(net_addr), .net_wdata(net_wdata),
        .req(req), .ack(ack),
        .in_offset(in_offset), .out_offset(out_offset), .net_offset(net_offset),
        .total_out(total_out), .total_in(total_in), .fil_size(fil_size),
        .busy(busy), .done(done)
`ifdef RENKON_DISPATCH_PERF_EN
        , .perf_load_cycles(perf_load_cycles), .perf_wait_cycles(perf_wait_cycles)
`endif
    );

    int n_total = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, last_idx = 0;
    int b_tout, b_nw, b_noff, grp, wr_in_grp;
    int wr_cnt, consumed, req_cnt, done_cnt;
    int start_tick, ack_tick, done_tick;
    logic [11:0] req_off [0:7];
    logic [15:0] tb_wdata = 16'hFFF0;
    bit s_req, s_done, s_busy;

    assign w_data = tb_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, tally, step past the edge.
    task automatic tick();
        int ec, ek;
        bit act, took;
        logic [15:0] wd;
        #1;
        last_idx = cyc;
        s_req  = (req === 1'b1);
        s_done = (done === 1'b1);
        s_busy = (busy === 1'b1);
        if (net_we === 1'b1) begin
            ec  = wr_in_grp / b_nw;
            ek  = wr_in_grp % b_nw;
            act = (grp * 8 + ec) < b_tout;
            wd  = net_wdata;
            chk("net_sel", {29'b0, net_sel}, ec);
            chk("net_addr", {21'b0, net_addr}, (b_noff + ek) & 32'h7FF);
            chk("net_wdata", {16'b0, wd}, act ? {16'b0, tb_wdata} : 32'd0);
            chk("w_ready", {31'b0, w_ready}, {31'b0, act});
            wr_cnt++;
            wr_in_grp++;
        end
        took = (w_valid === 1'b1) && (w_ready === 1'b1);
        if (took) consumed++;
        if (s_req) begin
            req_off[req_cnt % 8] = out_offset;
            req_cnt++;
            grp++;
            wr_in_grp = 0;
        end
        if (s_done) done_cnt++;
        @(posedge clk);
        #1;
        if (took) tb_wdata = tb_wdata + 16'd1;
        cyc++;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_req"}, {31'b0, req}, 0);
        chk({p, "_net_we"}, {31'b0, net_we}, 0);
        chk({p, "_w_ready"}, {31'b0, w_ready}, 0);
        chk({p, "_busy"}, {31'b0, busy}, 0);
        chk({p, "_done"}, {31'b0, done}, 0);
        chk({p, "_net_sel"}, {29'b0, net_sel}, 0);
        chk({p, "_net_addr"}, {21'b0, net_addr}, 0);
        chk({p, "_net_wdata"}, {16'b0, net_wdata}, 0);
        chk({p, "_in_off"}, {20'b0, in_offset}, 0);
        chk({p, "_out_off"}, {20'b0, out_offset}, 0);
        chk({p, "_net_off"}, {21'b0, net_offset}, 0);
        chk({p, "_tot_out"}, {22'b0, total_out}, 0);
        chk({p, "_tot_in"}, {22'b0, total_in}, 0);
        chk({p, "_fil"}, {22'b0, fil_size}, 0);
    endtask

    // Drives one layer: start, weight stream, ack 4 cycles into each WAIT.
    // noise: ack held high outside WAIT plus a mid-layer start pulse.
    // rst_wait: return while the DUT sits in WAIT (no ack given).
    task automatic run_layer(input int tout, input int tin, input int fs, input int noff,
                             input bit toggle, input bit noise, input bit rst_wait);
        bit pending = 0;
        int wait_n = 0;
        b_tout = tout; b_nw = (tin * fs * fs + 1) & 32'h7FF; b_noff = noff;
        grp = 0; wr_in_grp = 0; wr_cnt = 0; consumed = 0; req_cnt = 0; done_cnt = 0;
        ack_tick = -100; done_tick = -1;
        cfg_total_out = 10'(tout); cfg_total_in = 10'(tin); cfg_fil_size = 10'(fs);
        cfg_net_offset = 11'(noff);
        cfg_in_offset = 12'h321; cfg_out_offset = 12'h100; cfg_out_stride = 12'h040;
        w_valid = 1'b0; ack = 1'b0; start = 1'b1;
        tick();
        start_tick = last_idx;
        start = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            w_valid = toggle ? n[0] : 1'b1;
            ack = 1'b0;
            if (pending) begin
                if (rst_wait && wait_n == 2) break;
                ack = (wait_n == 3);
            end else begin
                ack = noise;
            end
            start = noise && (n == 6);
            cfg_total_out = (noise && n == 6) ? 10'd20 : 10'(tout);
            tick();
            start = 1'b0;
            cfg_total_out = 10'(tout);
            if (pending) begin
                if (ack) begin pending = 0; ack_tick = last_idx; end
                else wait_n++;
            end
            if (s_req) begin pending = 1; wait_n = 0; end
            if (s_done) begin
                done_tick = last_idx;
                w_valid = 1'b0; ack = 1'b0;
                tick();
                chk("idle_after_done", {31'b0, s_busy}, 0);
                break;
            end
        end
        w_valid = 1'b0;
        ack = 1'b0;
    endtask

    initial begin
        xrst = 1'b1; start = 1'b0; w_valid = 1'b0; ack = 1'b0;
        cfg_total_out = '0; cfg_total_in = '0; cfg_fil_size = '0;
        cfg_in_offset = '0; cfg_out_offset = '0; cfg_out_stride = '0; cfg_net_offset = '0;
        b_nw = 1; b_tout = 0; b_noff = 0; grp = 0; wr_in_grp = 0;
        repeat (3) tick();
        chk_zero("rst");
        xrst = 1'b0;
        tick();

        // 8 outputs, nw = 1*3*3+1 = 10, one full group
        run_layer(8, 1, 3, 0, 0, 0, 0);
        chk("t1_writes", wr_cnt, 80);
        chk("t1_consumed", consumed, 80);
        chk("t1_req", req_cnt, 1);
        chk("t1_done", done_cnt, 1);
        chk("t1_done_lat", done_tick - ack_tick, 2);
        chk("t1_out_off", {20'b0, out_offset}, 32'h140);
        chk("t1_total_out", {22'b0, total_out}, 8);

        // 10 outputs: group 2 has 2 live cores, 6 zero-filled
        run_layer(10, 1, 3, 0, 0, 0, 0);
        chk("t2_writes", wr_cnt, 160);
        chk("t2_consumed", consumed, 100);
        chk("t2_req", req_cnt, 2);
        chk("t2_off_g1", {20'b0, req_off[0]}, 32'h100);
        chk("t2_off_g2", {20'b0, req_off[1]}, 32'h140);
        chk("t2_done", done_cnt, 1);
        chk("t2_out_off", {20'b0, out_offset}, 32'h180);

        // valid toggling, nw = 2*2*2+1 = 9, address wraps past 2047
        run_layer(3, 2, 2, 2040, 1, 0, 0);
        chk("t3_writes", wr_cnt, 72);
        chk("t3_consumed", consumed, 27);
        chk("t3_req", req_cnt, 1);
        chk("t3_done", done_cnt, 1);

        // stray ack in LOAD/REQ and start mid-layer, nw = 2
        run_layer(5, 1, 1, 5, 0, 1, 0);
        chk("t4_writes", wr_cnt, 16);
        chk("t4_consumed", consumed, 10);
        chk("t4_req", req_cnt, 1);
        chk("t4_done", done_cnt, 1);
        chk("t4_done_lat", done_tick - ack_tick, 2);
        chk("t4_total_out", {22'b0, total_out}, 5);
        chk("t4_in_off", {20'b0, in_offset}, 32'h321);
        chk("t4_net_off", {21'b0, net_offset}, 5);

        // zero outputs: done straight after start
        run_layer(0, 3, 3, 0, 0, 0, 0);
        chk("t5_done_lat", done_tick - start_tick, 1);
        chk("t5_writes", wr_cnt, 0);
        chk("t5_req", req_cnt, 0);
        chk("t5_done", done_cnt, 1);

        // reset while waiting for ack
        run_layer(8, 1, 1, 7, 0, 0, 1);
        chk("t6_in_wait", {31'b0, busy}, 1);
        chk("t6_req", req_cnt, 1);
        xrst = 1'b1;
        tick();
        chk_zero("t6");
        xrst = 1'b0;
        done_cnt = 0;
        repeat (6) tick();
        chk("t6_no_done", done_cnt, 0);
        chk("t6_idle", {31'b0, busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/renkon_dispatch.md
RENKON_DISPATCH -- requirements
Module: renkon_dispatch

Interface
REQ-001 Parameters SHALL come from renkon.svh: RENKON_CORE, default 8, number of PE cores.
REQ-002 Parameter RENKON_CORELOG SHALL default to 3 and give the core select width.
REQ-003 Parameter RENKON_NETSIZE SHALL default to 11 and give the per-core net memory address width.
REQ-004 Parameter DWIDTH SHALL default to 16 and give the data width; LWIDTH SHALL default to 10 and give the layer parameter width; IMGSIZE SHALL default to 12 and give the image address width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 xrst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse that begins a layer; sampled only in IDLE.
REQ-008 cfg_total_out, cfg_total_in, cfg_fil_size  in  LWIDTH each  layer geometry, captured on accepted start.
REQ-009 cfg_in_offset, cfg_out_offset, cfg_out_stride  in  IMGSIZE each  image base addresses and per-group output advance.
REQ-010 cfg_net_offset  in  RENKON_NETSIZE  net memory base address, captured on start.
REQ-011 w_valid, w_data  in  1, DWIDTH (signed)  weight stream; w_ready  out  1.
REQ-012 net_sel  out  RENKON_CORELOG; net_we  out  1; net_addr  out  RENKON_NETSIZE; net_wdata  out  DWIDTH (signed).
REQ-013 req  out  1; ack  in  1  accelerator handshake.
REQ-014 in_offset, out_offset  out  IMGSIZE; net_offset  out  RENKON_NETSIZE; total_out, total_in, fil_size  out  LWIDTH.
REQ-015 busy  out  1; done  out  1  one-cycle pulse when the layer completes.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, REQ, WAIT and DONE.
REQ-017 IDLE->LOAD SHALL occur on start; if the captured total_out is 0, IDLE->DONE SHALL occur instead.
REQ-018 Words per core SHALL be nw = total_in*fil_size*fil_size + 1 (bias last), computed at full width on start and truncated to RENKON_NETSIZE.
REQ-019 LOAD SHALL iterate core c = 0..RENKON_CORE-1 and word k = 0..nw-1, driving net_sel=c, net_addr=net_offset+k (modulo 2^RENKON_NETSIZE) and net_wdata=w_data.
REQ-020 A word SHALL transfer only on w_valid&w_ready, with net_we equal to that transfer in the same cycle; with no transfer, the counters SHALL hold.
REQ-021 In the final group, cores c >= remaining channels SHALL get nw zero writes with w_ready=0 and no stream consumption.
REQ-022 After the last word of core RENKON_CORE-1, the FSM SHALL go LOAD->REQ; in REQ, req=1 for exactly one cycle, then the FSM SHALL enter WAIT.
REQ-023 In WAIT, ack=1 SHALL end the group: the group counter increments and out_offset advances by cfg_out_stride (wraps modulo 2^IMGSIZE).
REQ-024 After a group ends, the FSM SHALL return to LOAD if groups remain (ceil(total_out/RENKON_CORE)), otherwise go to DONE.
REQ-025 ack outside WAIT SHALL be ignored; start while busy SHALL be ignored.
REQ-026 DONE SHALL pulse done=1 for one cycle, then return to IDLE; busy=1 in every state except IDLE.
REQ-027 The layer parameter outputs SHALL stay stable from start capture through WAIT.

Reset
REQ-028 While xrst=1, the FSM SHALL go to IDLE and req, net_we, w_ready, busy, done, net_sel, net_addr, net_wdata and all counters/offset outputs SHALL be 0.
REQ-029 Reset mid-LOAD or mid-WAIT SHALL abandon the layer without a done pulse; any consumed stream words are lost.

Configuration
REQ-030 With RENKON_DISPATCH_PERF_EN defined, outputs perf_load_cycles and perf_wait_cycles (32 bits each, saturating) SHALL count LOAD and WAIT cycles, cleared on accepted start; without it, these ports and counters SHALL not exist.

Verification
REQ-031 total_out=8, total_in=1, fil_size=3, net_offset=0, w_valid always 1 -> 80 net_we writes, addr 0..9 per core, one req, done two cycles after ack.
REQ-032 total_out=10 -> two groups; group 2 writes cores 2..7 with zeros, consumes 20 words only, out_offset=cfg_out_offset+cfg_out_stride.
REQ-033 w_valid toggled 1/0 every cycle -> net_we only on valid cycles, addresses contiguous, total word count unchanged.
REQ-034 ack asserted during LOAD and REQ, start pulsed mid-layer -> both ignored, single group completes normally.
REQ-035 total_out=0 -> done one cycle after start, no req, no net_we; xrst pulse in WAIT -> all outputs 0, no done.
